rx_logic: RTL and testbench

Receive-side collector for a router node. Gathers flits from PORT_COUNT rx transceivers over 2-phase req/ack handshakes, arbitrates round-robin, and pushes one flit per cycle into the node's input fifo. It sits directly upstream of that fifo, mirroring the tx-side dispatcher that pops it.

---
 rtl/noc_defs_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rx_logic.sv | 103 ++++++++++
 tb/tb_rx_logic.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_defs_pkg.sv
// Shared router-node definitions: default flit/port/counter sizes and flit packing helper.
// Used by both the rx collector and the tx dispatcher.
package noc_defs_pkg;

  localparam int unsigned DefSize      = 8;
  localparam int unsigned DefPortCount = 5;
  localparam int unsigned DefCountBits = 16;

  // LSB position of a port's flit inside a packed multi-port data bus.
  function automatic int unsigned flit_lsb(int unsigned port, int unsigned size);
    return port * size;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first pending port at or after rr_ptr_i, wrapping.
// The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int unsigned PORT_COUNT = 5,
  parameter int unsigned PTR_W      = 3
) (
  input  logic [PORT_COUNT-1:0] pending_i,
  input  logic [PTR_W-1:0]      rr_ptr_i,
  input  logic                  enable_i,
  output logic [PORT_COUNT-1:0] grant_o,
  output logic [PTR_W-1:0]      sel_o,
  output logic                  valid_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant_o = '0;
    sel_o   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      idx = int'(rr_ptr_i) + i;
      if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
      if (enable_i && !found && pending_i[idx]) begin
        found        = 1'b1;
        sel_o        = PTR_W'(idx);
        grant_o[idx] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rx_logic.sv
// Receive-side collector: 2-phase req/ack per port, round-robin into a one-entry output register.
// Define RX_LOGIC_DEBUG_EN to print accept/write trace messages.
module rx_logic
  import noc_defs_pkg::*;
#(
  parameter int          ID         = -1,
  parameter int unsigned SIZE       = DefSize,
  parameter int unsigned PORT_COUNT = DefPortCount,
  parameter int unsigned COUNT_BITS = DefCountBits
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORT_COUNT-1:0]      fifo_push_req,
  output logic [PORT_COUNT-1:0]      fifo_push_ack,
  input  logic [PORT_COUNT*SIZE-1:0] fifo_push_data,
  output logic                       fifo_write,
  input  logic                       fifo_full,
  output logic [SIZE-1:0]            fifo_item_in,
  output logic [COUNT_BITS-1:0]      flit_count
);

  localparam int unsigned PtrW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [PORT_COUNT-1:0] ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [SIZE-1:0]       data_q, data_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;

  logic [PORT_COUNT-1:0] pending;
  logic [PORT_COUNT-1:0] grant;
  logic [PtrW-1:0]       sel;
  logic                  accept;
  logic                  load;
  logic [SIZE-1:0]       flit_sel;

  assign pending    = fifo_push_req ^ ack_q;
  assign fifo_write = valid_q & ~fifo_full;
  assign load       = ~valid_q | fifo_write;
  assign flit_sel   = fifo_push_data[flit_lsb(int'(sel), SIZE) +: SIZE];

  rr_arbiter #(
    .PORT_COUNT(PORT_COUNT),
    .PTR_W     (PtrW)
  ) u_arb (
    .pending_i(pending),
    .rr_ptr_i (ptr_q),
    .enable_i (load),
    .grant_o  (grant),
    .sel_o    (sel),
    .valid_o  (accept)
  );

  always_comb begin
    ack_d   = ack_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q & ~fifo_write;
    if (fifo_write) cnt_d = cnt_q + COUNT_BITS'(1);
    // A write and a new accept on the same edge simply replace the register.
    if (accept) begin
      data_d  = flit_sel;
      valid_d = 1'b1;
      ack_d   = ack_q ^ grant;
      ptr_d   = (sel == PtrW'(PORT_COUNT - 1)) ? '0 : sel + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_push_ack = ack_q;
  assign fifo_item_in  = data_q;
  assign flit_count    = cnt_q;

`ifdef RX_LOGIC_DEBUG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        $display("%0t, RX_LOGIC [%0d] : accepted %h from port %0d", $time, ID, flit_sel, sel);
      end
      if (fifo_write) begin
        $display("%0t, RX_LOGIC [%0d] : wrote %h to fifo", $time, ID, data_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_logic.sv
// Bench for rx_logic: directed scenarios plus random traffic, checked by a scoreboard fed
// from a behavioural arbitration model (COUNT_BITS=4 so the counter wraps often).
module tb_rx_logic;

  localparam int unsigned SIZE = 8;
  localparam int unsigned P    = 5;
  localparam int unsigned CB   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [P-1:0]    fifo_push_req;
  logic [P-1:0]    fifo_push_ack;
  logic [P*SIZE-1:0] fifo_push_data;
  logic            fifo_write;
  logic            fifo_full;
  logic [SIZE-1:0] fifo_item_in;
  logic [CB-1:0]   flit_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: acks, held-flit flag, pointer, count; queue of {port, flit} awaiting write.
  logic [P-1:0] m_ack = '0;
  bit           m_valid = 0;
  int           m_ptr = 0;
  int           m_cnt = 0;
  int           exp_q[$];

  rx_logic #(
    .ID        (3),
    .SIZE      (SIZE),
    .PORT_COUNT(P),
    .COUNT_BITS(CB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_push_req (fifo_push_req),
    .fifo_push_ack (fifo_push_ack),
    .fifo_push_data(fifo_push_data),
    .fifo_write    (fifo_write),
    .fifo_full     (fifo_full),
    .fifo_item_in  (fifo_item_in),
    .flit_count    (flit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one accept per edge, first pending port scanning from the pointer.
  always @(posedge clk) begin
    bit wr;
    bit found;
    int sel;
    if (reset) begin
      m_ack   = '0;
      m_valid = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      wr    = m_valid && !fifo_full;
      found = 0;
      sel   = 0;
      if (wr) m_cnt = (m_cnt + 1) % (1 << CB);
      if (!m_valid || wr) begin
        for (int i = 0; i < P; i++) begin
          int p;
          p = (m_ptr + i) % P;
          if (!found && (fifo_push_req[p] != m_ack[p])) begin
            found = 1;
            sel   = p;
          end
        end
        if (found) begin
          exp_q.push_back(sel * 256 + int'(fifo_push_data[sel*SIZE +: SIZE]));
          m_ack[sel] = ~m_ack[sel];
          m_ptr      = (sel + 1) % P;
          m_valid    = 1;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Monitor: pops an expected flit whenever the DUT writes to the fifo.
  always @(negedge clk) begin
    int e;
    check("fifo_write", {31'd0, fifo_write}, {31'd0, m_valid && !fifo_full});
    if (fifo_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("fifo_item_in", {24'd0, fifo_item_in}, e & 255);
      end
    end
    check("ack", {27'd0, fifo_push_ack}, {27'd0, m_ack});
    check("flit_count", {28'd0, flit_count}, m_cnt);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input int k, input logic [SIZE-1:0] d);
    fifo_push_data[k*SIZE +: SIZE] = d;
    fifo_push_req[k] = ~fifo_push_req[k];
  endtask

  logic [P-1:0] pre;

  initial begin
    reset          = 1'b1;
    fifo_push_req  = '0;
    fifo_push_data = '0;
    fifo_full      = 1'b0;
    cycles(2);
    check("rst_write", {31'd0, fifo_write}, 32'd0);
    check("rst_item", {24'd0, fifo_item_in}, 32'd0);
    check("rst_count", {28'd0, flit_count}, 32'd0);
    reset = 1'b0;

    // Single flit on port 2.
    toggle(2, 8'h5A);
    cycles(1);
    check("single_ack", {31'd0, fifo_push_ack[2]}, 32'd1);
    check("single_write", {31'd0, fifo_write}, 32'd1);
    check("single_item", {24'd0, fifo_item_in}, 32'h5A);
    cycles(1);
    check("single_count", {28'd0, flit_count}, 32'd1);

    // Port 4 alone brings the pointer back to 0, then all five ports at once.
    toggle(4, 8'h44);
    cycles(3);
    for (int k = 0; k < P; k++) toggle(k, 8'h10 + 8'(k));
    cycles(7);
    check("all5_count", {28'd0, flit_count}, 32'd7);

    // Pointer to 3 via port 2, then ports 1 and 4: port 4 goes first.
    toggle(2, 8'h22);
    cycles(3);
    toggle(1, 8'hA1);
    toggle(4, 8'hA4);
    cycles(1);
    check("wrap_first", {24'd0, fifo_item_in}, 32'hA4);
    cycles(1);
    check("wrap_second", {24'd0, fifo_item_in}, 32'hA1);
    cycles(2);

    // Backpressure with ports 0 and 1 pending.
    pre       = fifo_push_req;
    fifo_full = 1'b1;
    toggle(0, 8'hB0);
    toggle(1, 8'hB1);
    cycles(4);
    check("bp_ack0", {31'd0, fifo_push_ack[0]}, {31'd0, ~pre[0]});
    check("bp_ack1", {31'd0, fifo_push_ack[1]}, {31'd0, pre[1]});
    check("bp_hold", {24'd0, fifo_item_in}, 32'hB0);
    fifo_full = 1'b0;
    @(negedge clk);
    check("bp_resume", {31'd0, fifo_write}, 32'd1);
    cycles(3);

    // Reset while a flit is held and port 3 still pending.
    fifo_full = 1'b1;
    toggle(2, 8'hC2);
    toggle(3, 8'hC3);
    cycles(2);
    reset         = 1'b1;
    fifo_push_req = '0;
    fifo_full     = 1'b0;
    cycles(1);
    check("rstmid_ack", {27'd0, fifo_push_ack}, 32'd0);
    check("rstmid_write", {31'd0, fifo_write}, 32'd0);
    check("rstmid_count", {28'd0, flit_count}, 32'd0);
    reset = 1'b0;
    cycles(2);

    // 17 flits through a 4-bit counter.
    for (int n = 0; n < 17; n++) begin
      toggle(0, 8'(n));
      cycles(2);
    end
    check("count_wrap", {28'd0, flit_count}, 32'd1);

    // Random traffic and backpressure.
    for (int c = 0; c < 400; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < P; k++) begin
        if (fifo_push_req[k] == fifo_push_ack[k] && $urandom_range(0, 1) == 1) begin
          toggle(k, 8'($urandom));
        end
      end
      cycles(1);
    end

    // Drain within a fixed budget.
    fifo_full = 1'b0;
    cycles(30);
    check("drain_queue", exp_q.size(), 32'd0);
    check("drain_pending", {27'd0, fifo_push_req ^ fifo_push_ack}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
